// File: rtl/sa_pkg.sv
// Shared constants, types and the skew-index helper for the 4x4 systolic-array sequencer.
package sa_pkg;

  localparam int N        = 8;
  localparam int DIM      = 4;
  localparam int FEED_CYC = 3*DIM-2;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, OUT} state_t;

  typedef logic [DIM*DIM-1:0][N-1:0] mat_t;
  typedef logic [DIM-1:0][N-1:0]     vec_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] k;
  } skew_t;

  // Lane `lane` consumes element k = t - lane while that falls inside 0..DIM-1.
  function automatic skew_t skew_idx(input logic [3:0] t, input logic [1:0] lane);
    logic [4:0] diff;
    skew_t      r;
    diff    = {1'b0, t} - {3'b000, lane};
    r.valid = ~diff[4] & (diff[3:2] == 2'b00);
    r.k     = diff[1:0];
    return r;
  endfunction

endpackage

// File: rtl/sa_skew_feed.sv
// Registered diagonal-skew mux: row i carries A[i][t-i], column j carries B[t-j][j], zero outside the window.
module sa_skew_feed
  import sa_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       feed_en,
  input  logic [3:0] t,
  input  mat_t       a_buf,
  input  mat_t       b_buf,
  output vec_t       arr_row,
  output vec_t       arr_col
);

  vec_t row_next;
  vec_t col_next;

  // Row i and column i share the same skew offset, so one lookup serves both.
  for (genvar i = 0; i < DIM; i++) begin : g_lane
    skew_t sk;
    assign sk          = skew_idx(t, 2'(i));
    assign row_next[i] = (feed_en && sk.valid) ? a_buf[{2'(i), sk.k}] : '0;
    assign col_next[i] = (feed_en && sk.valid) ? b_buf[{sk.k, 2'(i)}] : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      arr_row <= '0;
      arr_col <= '0;
    end else begin
      arr_row <= row_next;
      arr_col <= col_next;
    end
  end

endmodule

// File: rtl/sa_ctrl.sv
// Sequencer for the 4x4 output-stationary systolic array: buffers A/B, feeds them skewed,
// drains C through the row outputs and streams the 16 results back to the host.
module sa_ctrl
  import sa_pkg::*;
#(
  parameter int DRAIN_LAT = 1
)
(
  input  logic         clk,
  input  logic         rstn,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic         ld_sel,
  input  logic [3:0]   ld_addr,
  input  logic [N-1:0] ld_data,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic [3:0]   res_idx,
  output logic         res_last,
  output logic [N-1:0] arr_row_0,
  output logic [N-1:0] arr_row_1,
  output logic [N-1:0] arr_row_2,
  output logic [N-1:0] arr_row_3,
  output logic [N-1:0] arr_col_0,
  output logic [N-1:0] arr_col_1,
  output logic [N-1:0] arr_col_2,
  output logic [N-1:0] arr_col_3,
  input  logic [N-1:0] arr_out_0,
  input  logic [N-1:0] arr_out_1,
  input  logic [N-1:0] arr_out_2,
  input  logic [N-1:0] arr_out_3,
  output logic         arr_output_sign
);

  // The sign output lags the DRAIN state by one cycle, so sample d lands at dcnt = DRAIN_LAT + d.
  localparam logic [7:0] CAP_FIRST  = 8'(DRAIN_LAT);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_LAT + DIM - 1);

  state_t     state;
  state_t     next_state;
  logic [3:0] t;
  logic [7:0] dcnt;
  logic [1:0] cap_col;
  mat_t       a_buf;
  mat_t       b_buf;
  mat_t       c_buf;
  vec_t       row_v;
  vec_t       col_v;
  vec_t       out_v;
  logic       res_fire;

  assign out_v    = {arr_out_3, arr_out_2, arr_out_1, arr_out_0};
  assign cap_col  = ~2'(dcnt - CAP_FIRST);
  assign res_fire = res_valid && res_ready;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = FEED;
      FEED:    if (t == 4'(FEED_CYC-1)) next_state = DRAIN;
      DRAIN:   if (dcnt == DRAIN_LAST) next_state = OUT;
      OUT:     if (res_fire && res_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      t     <= '0;
      dcnt  <= '0;
    end else begin
      state <= next_state;
      t     <= (state == FEED  && next_state == FEED)  ? t + 4'd1    : '0;
      dcnt  <= (state == DRAIN && next_state == DRAIN) ? dcnt + 8'd1 : '0;
    end
  end

  sa_skew_feed u_feed (
    .clk     (clk),
    .rstn    (rstn),
    .feed_en (state == FEED),
    .t       (t),
    .a_buf   (a_buf),
    .b_buf   (b_buf),
    .arr_row (row_v),
    .arr_col (col_v)
  );

  assign arr_row_0 = row_v[0];
  assign arr_row_1 = row_v[1];
  assign arr_row_2 = row_v[2];
  assign arr_row_3 = row_v[3];
  assign arr_col_0 = col_v[0];
  assign arr_col_1 = col_v[1];
  assign arr_col_2 = col_v[2];
  assign arr_col_3 = col_v[3];

  // Buffer contents are not reset; they are always rewritten before being meaningful.
  always_ff @(posedge clk) begin
    if (state == IDLE && ld_valid) begin
      if (ld_sel) b_buf[ld_addr] <= ld_data;
      else        a_buf[ld_addr] <= ld_data;
    end
    if (state == DRAIN && dcnt >= CAP_FIRST) begin
      for (int k = 0; k < DIM; k++) c_buf[{2'(k), cap_col}] <= out_v[k];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ld_ready        <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      arr_output_sign <= 1'b0;
      res_valid       <= 1'b0;
      res_data        <= '0;
      res_idx         <= '0;
      res_last        <= 1'b0;
    end else begin
      ld_ready        <= (next_state == IDLE);
      busy            <= (next_state != IDLE);
      done            <= (state == OUT) && res_fire && res_last;
      arr_output_sign <= (state == DRAIN);
      if (state == OUT) begin
        if (!res_valid) begin
          res_valid <= 1'b1;
          res_idx   <= '0;
          res_data  <= c_buf[0];
          res_last  <= 1'b0;
        end else if (res_ready) begin
          if (res_last) begin
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_data  <= '0;
            res_last  <= 1'b0;
          end else begin
            res_idx  <= res_idx + 4'd1;
            res_data <= c_buf[res_idx + 4'd1];
            res_last <= (res_idx == 4'd14);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sa_ctrl.sv
// Directed bench for sa_ctrl with a behavioural 4x4 output-stationary array model attached.
module tb_sa_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       ld_valid, ld_ready, ld_sel;
  logic [3:0] ld_addr;
  logic [7:0] ld_data;
  logic       start, busy, done;
  logic       res_valid, res_ready, res_last;
  logic [7:0] res_data;
  logic [3:0] res_idx;
  logic [7:0] arr_row_0, arr_row_1, arr_row_2, arr_row_3;
  logic [7:0] arr_col_0, arr_col_1, arr_col_2, arr_col_3;
  logic [7:0] arr_out_0, arr_out_1, arr_out_2, arr_out_3;
  logic       arr_output_sign;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [7:0] matA [16];
  logic [7:0] matB [16];
  logic [7:0] expC [16];

  always #5 clk = ~clk;

  sa_ctrl #(.DRAIN_LAT(1)) dut (
    .clk(clk), .rstn(rstn),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .busy(busy), .done(done),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx), .res_last(res_last),
    .arr_row_0(arr_row_0), .arr_row_1(arr_row_1), .arr_row_2(arr_row_2), .arr_row_3(arr_row_3),
    .arr_col_0(arr_col_0), .arr_col_1(arr_col_1), .arr_col_2(arr_col_2), .arr_col_3(arr_col_3),
    .arr_out_0(arr_out_0), .arr_out_1(arr_out_1), .arr_out_2(arr_out_2), .arr_out_3(arr_out_3),
    .arr_output_sign(arr_output_sign)
  );

  // Array model: operands hop one PE per cycle, MAC while sign is low, shift right toward col 3 while high.
  logic [7:0] rowIn [4];
  logic [7:0] colIn [4];
  logic [7:0] accM  [4][4];
  logic [7:0] aPipe [4][4];
  logic [7:0] bPipe [4][4];

  assign rowIn[0] = arr_row_0;
  assign rowIn[1] = arr_row_1;
  assign rowIn[2] = arr_row_2;
  assign rowIn[3] = arr_row_3;
  assign colIn[0] = arr_col_0;
  assign colIn[1] = arr_col_1;
  assign colIn[2] = arr_col_2;
  assign colIn[3] = arr_col_3;

  assign arr_out_0 = arr_output_sign ? accM[0][3] : 8'h00;
  assign arr_out_1 = arr_output_sign ? accM[1][3] : 8'h00;
  assign arr_out_2 = arr_output_sign ? accM[2][3] : 8'h00;
  assign arr_out_3 = arr_output_sign ? accM[3][3] : 8'h00;

  function automatic logic [7:0] aInOf(int i, int j);
    if (j == 0) return rowIn[i];
    return aPipe[i][j-1];
  endfunction

  function automatic logic [7:0] bInOf(int i, int j);
    if (i == 0) return colIn[j];
    return bPipe[i-1][j];
  endfunction

  function automatic logic [7:0] leftAcc(int i, int j);
    if (j == 0) return 8'h00;
    return accM[i][j-1];
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          accM[i][j]  <= 8'h00;
          aPipe[i][j] <= 8'h00;
          bPipe[i][j] <= 8'h00;
        end
    end else begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          aPipe[i][j] <= aInOf(i, j);
          bPipe[i][j] <= bInOf(i, j);
          if (arr_output_sign) accM[i][j] <= leftAcc(i, j);
          else                 accM[i][j] <= 8'(accM[i][j] + aInOf(i, j) * bInOf(i, j));
        end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic loadElem(input logic sel, input logic [3:0] addr, input logic [7:0] data);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_addr  = addr;
    ld_data  = data;
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  // Loads A and B (last B write shares its cycle with start) or just pulses start.
  task automatic applyStimulus(input bit doLoad);
    checkOutput("ld_ready in idle", ld_ready, 1);
    if (doLoad) begin
      for (int k = 0; k < 16; k++) loadElem(1'b0, 4'(k), matA[k]);
      for (int k = 0; k < 15; k++) loadElem(1'b1, 4'(k), matB[k]);
      ld_valid = 1'b1;
      ld_sel   = 1'b1;
      ld_addr  = 4'd15;
      ld_data  = matB[15];
    end
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    ld_valid = 1'b0;
    checkOutput("busy after start", busy, 1);
    checkOutput("ld_ready after start", ld_ready, 0);
  endtask

  task automatic collectResults(input bit randReady, input bit checkTiming, input bit disturb);
    int         cyc = 0;
    int         idx = 0;
    int         firstValid = -1;
    int         doneCount = 0;
    bit         pendingLast = 0;
    bit         finished = 0;
    bit         prevValid = 0;
    bit         prevReady = 0;
    logic [7:0] prevData = 8'h00;
    logic [3:0] prevIdx = 4'h0;
    res_ready = 1'b0;
    while (!finished && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      doneCount += int'(done);
      if (checkTiming && cyc >= 1 && cyc <= 10) begin
        for (int i = 0; i < 4; i++) begin
          int k = cyc - 1 - i;
          logic [7:0] expRow = (k >= 0 && k <= 3) ? matA[i*4 + k] : 8'h00;
          logic [7:0] expCol = (k >= 0 && k <= 3) ? matB[k*4 + i] : 8'h00;
          checkOutput($sformatf("arr_row_%0d t=%0d", i, cyc - 1), rowIn[i], expRow);
          checkOutput($sformatf("arr_col_%0d t=%0d", i, cyc - 1), colIn[i], expCol);
        end
      end
      if (checkTiming && cyc == 10) checkOutput("sign low during feed", arr_output_sign, 0);
      if (checkTiming && cyc == 11) begin
        checkOutput("sign high at drain entry", arr_output_sign, 1);
        checkOutput("arr_row_3 zero in drain", arr_row_3, 0);
      end
      if (checkTiming && cyc == 15) checkOutput("sign high last drain cycle", arr_output_sign, 1);
      if (checkTiming && cyc == 16) checkOutput("sign low in out", arr_output_sign, 0);
      if (disturb && cyc == 3) begin
        checkOutput("ld_ready while busy", ld_ready, 0);
        start    = 1'b1;
        ld_valid = 1'b1;
        ld_sel   = 1'b0;
        ld_addr  = 4'd0;
        ld_data  = 8'h55;
      end
      if (disturb && cyc == 4) begin
        start    = 1'b0;
        ld_valid = 1'b0;
      end
      if (disturb && cyc == 20) start = 1'b1;
      if (disturb && cyc == 21) start = 1'b0;
      if (pendingLast) begin
        checkOutput("done after last handshake", done, 1);
        checkOutput("res_valid after last", res_valid, 0);
        if (checkTiming) checkOutput("start-to-done cycles", cyc, 32);
        finished = 1;
      end else begin
        if (prevValid && !prevReady) begin
          checkOutput("res_valid held in stall", res_valid, 1);
          checkOutput("res_data held in stall", res_data, prevData);
          checkOutput("res_idx held in stall", res_idx, prevIdx);
        end
        if (res_valid && firstValid < 0) begin
          firstValid = cyc;
          if (checkTiming) checkOutput("first res_valid cycle", cyc, 16);
        end
        prevReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        res_ready = prevReady;
        prevValid = res_valid;
        prevData  = res_data;
        prevIdx   = res_idx;
        if (res_valid && prevReady) begin
          checkOutput($sformatf("res_data idx %0d", idx), res_data, expC[idx]);
          checkOutput($sformatf("res_idx order %0d", idx), res_idx, idx);
          checkOutput($sformatf("res_last idx %0d", idx), res_last, (idx == 15));
          idx++;
          if (idx == 16) pendingLast = 1;
        end
      end
    end
    res_ready = 1'b0;
    start     = 1'b0;
    ld_valid  = 1'b0;
    checkOutput("results received", idx, 16);
    checkOutput("stream finished in budget", finished, 1);
    @(posedge clk); #1;
    doneCount += int'(done);
    checkOutput("done is one cycle", done, 0);
    checkOutput("done pulse count", doneCount, 1);
    checkOutput("busy after op", busy, 0);
    checkOutput("ld_ready after op", ld_ready, 1);
  endtask

  task automatic setMatrices(input int mode);
    for (int k = 0; k < 16; k++) begin
      case (mode)
        0: begin matA[k] = (k / 4 == k % 4) ? 8'd1 : 8'd0; matB[k] = 8'(k); expC[k] = 8'(k); end
        1: begin matA[k] = 8'd2;  matB[k] = 8'd3;  expC[k] = 8'd24; end
        2: begin matA[k] = 8'd16; matB[k] = 8'd16; expC[k] = 8'd0;  end
        default: begin matA[k] = 8'd1; matB[k] = 8'd1; expC[k] = 8'd4; end
      endcase
    end
  endtask

  initial begin
    rstn      = 1'b0;
    ld_valid  = 1'b0;
    ld_sel    = 1'b0;
    ld_addr   = 4'd0;
    ld_data   = 8'd0;
    start     = 1'b0;
    res_ready = 1'b0;
    #12;
    checkOutput("reset ld_ready", ld_ready, 1);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset res_valid", res_valid, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset sign", arr_output_sign, 0);
    checkOutput("reset arr_row_0", arr_row_0, 0);
    checkOutput("reset arr_col_3", arr_col_3, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    setMatrices(0);
    applyStimulus(1);
    collectResults(0, 0, 0);

    setMatrices(1);
    applyStimulus(1);
    collectResults(0, 1, 0);

    setMatrices(2);
    applyStimulus(1);
    collectResults(0, 0, 0);

    applyStimulus(1);
    collectResults(1, 0, 0);

    setMatrices(3);
    applyStimulus(1);
    collectResults(0, 0, 1);
    applyStimulus(0);
    collectResults(0, 0, 0);

    setMatrices(0);
    applyStimulus(1);
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    checkOutput("mid-feed reset arr_row_0", arr_row_0, 0);
    checkOutput("mid-feed reset arr_row_3", arr_row_3, 0);
    checkOutput("mid-feed reset arr_col_2", arr_col_2, 0);
    checkOutput("mid-feed reset busy", busy, 0);
    checkOutput("mid-feed reset ld_ready", ld_ready, 1);
    @(posedge clk); #1;
    checkOutput("reset held arr_col_1", arr_col_1, 0);
    checkOutput("reset held sign", arr_output_sign, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1);
    collectResults(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sa_ctrl.md
# sa_ctrl

Sequencer for the 4x4 output-stationary systolic array. It buffers one A and one B 4x4 matrix of 8-bit elements loaded by a host, and streams them into the array with the diagonal skew the array needs. It then asserts the array's output-shift control to drain the accumulated C = A·B through the row outputs, and returns the 16 results to the host over a valid/ready stream. It sits between the host/bus glue and the array instance.

## Interface
- N, 8, element and accumulator width; fixed to the array's width
- DIM, 4, array dimension; only 4 is supported
- DRAIN_LAT, 1, cycles from arr_output_sign rising to the first valid arr_out_k sample
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- ld_valid / ld_ready  in / out  1 / 1  load handshake; ld_ready = 1 only in IDLE
- ld_sel  in  1  0 = A, 1 = B
- ld_addr  in  4  row*4+col
- ld_data  in  N  element
- start  in  1  begin computation; honoured only in IDLE
- busy  out  1  high in FEED, DRAIN, OUT
- done  out  1  one-cycle pulse after the last result handshake
- res_valid / res_ready  out / in  1 / 1  result handshake
- res_data  out  N  C element
- res_idx  out  4  row*4+col of res_data
- res_last  out  1  high with idx 15
- arr_row_0..3  out  N  A inputs to array rows
- arr_col_0..3  out  N  B inputs to array columns
- arr_out_0..3  in  N  array row outputs
- arr_output_sign  out  1  array drain/shift control

## Operation
- States: IDLE → FEED → DRAIN → OUT → IDLE.
- IDLE: each ld handshake writes A or B buffer entry. Buffers persist across operations. start → FEED with feed counter t = 0. start outside IDLE is ignored.
- FEED (10 cycles, t = 0..9):
  - arr_row_i = A[i][t-i] when 0 ≤ t-i ≤ 3, else 0.
  - arr_col_j = B[t-j][j] when 0 ≤ t-j ≤ 3, else 0.
  - arr_output_sign = 0. At t = 9 → DRAIN.
- DRAIN (DRAIN_LAT + 4 cycles):
  - arr_output_sign = 1; all arr_row/arr_col = 0.
  - Drain sample d = 0..3 is taken DRAIN_LAT + d cycles after entry; arr_out_k is written to C[k][3-d].
  - Zeros shifted in at column 0 leave every accumulator cleared. Back-to-back operations need no extra clear.
  - After the last sample → OUT, with arr_output_sign back to 0.
- OUT: stream C in row-major order, idx 0..15.
  - res_data/res_idx stay stable while res_valid && !res_ready.
  - Handshake at idx 15 (res_last) → IDLE with done pulsed that cycle.
- Arithmetic: the array wraps modulo 2^N. The controller does no widening or saturation.
- Reset, any time: state IDLE, counters 0, all outputs 0 except ld_ready = 1. A/B/C buffer contents are undefined after reset. Reset mid-FEED or mid-DRAIN is recovered by the next operation only because the array's own rstn (shared) clears the PEs.

## Timing
- start sampled at edge e → first skewed data on arr_row_0/arr_col_0 in cycle e+1.
- Drain entry at e+11. res_valid first high at e+11+DRAIN_LAT+4 (e+16 for default).
- Minimum start-to-done with res_ready held high: 16 + 16 = 32 cycles for DRAIN_LAT = 1.
- All outputs are registered. No combinational path from res_ready or ld_valid to any output.
- ld_ready and start in the same cycle: the load completes and start is honoured. FEED uses the buffer including that write.

## Structure
- Package sa_pkg:
  - N, DIM, FEED_CYC = 3*DIM-2
  - state enum {IDLE, FEED, DRAIN, OUT}
  - helper function computing the skew index
- Sub-module sa_skew_feed: combinational/registered mux producing arr_row_*/arr_col_* from the buffers and t. It is instantiated once.
- C buffer: 16×N register file inside sa_ctrl.

## Test plan
- A = identity, B[r][c] = 4r+c → results idx 0..15 equal 0..15 in order; res_last only with idx 15; done pulses once.
- A all 2, B all 3 → all 16 results = 24.
- A all 16, B all 16 → 1024 mod 256 = 0 for every result (wrap check).
- Random res_ready with 50% duty on the previous case → same values and order; res_data stable while stalled; no handshake lost or duplicated.
- start pulsed during FEED and OUT → ignored; ld_valid during busy → ld_ready = 0 and buffers unchanged. Then a back-to-back second operation with A all 1, B all 1 → all results 4, confirming the drain cleared the accumulators.
- rstn asserted at FEED t = 5, then reload identity/ramp and start → outputs 0 during reset; correct 0..15 results afterward.
